// File: rtl/dm_arbiter_pkg.sv
// Shared requester IDs for the D-mem arbiter and its route queue.
package dm_arbiter_pkg;

  typedef enum logic {
    ARB_ID_LSP = 1'b0,
    ARB_ID_AUX = 1'b1
  } arb_id_e;

endpackage

// File: rtl/dm_arb_route_fifo.sv
// In-order route queue: one requester ID per accepted-but-unanswered D-mem request.
module dm_arb_route_fifo
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  arb_id_e                  push_id,
  input  logic                     pop,
  output arb_id_e                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  arb_id_e         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= ARB_ID_LSP;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester D-mem port arbiter with in-order response routing.
// DMARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority with starvation guard.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [63:0]                        p0_req_addr,
  input  logic [63:0]                        p0_req_wdata,
  input  logic [7:0]                         p0_req_wmask,
  input  logic                               p0_req_wen,
  input  logic                               p0_req_valid,
  output logic                               p0_req_ready,
  output logic                               p0_resp_valid,
  output logic [63:0]                        p0_resp_rdata,
  input  logic [63:0]                        p1_req_addr,
  input  logic [63:0]                        p1_req_wdata,
  input  logic [7:0]                         p1_req_wmask,
  input  logic                               p1_req_wen,
  input  logic                               p1_req_valid,
  output logic                               p1_req_ready,
  output logic                               p1_resp_valid,
  output logic [63:0]                        p1_resp_rdata,
  output logic [63:0]                        dm_req_addr,
  output logic [63:0]                        dm_req_wdata,
  output logic [7:0]                         dm_req_wmask,
  output logic                               dm_req_wen,
  output logic                               dm_req_valid,
  input  logic                               dm_req_ready,
  input  logic [63:0]                        dm_resp_rdata,
  input  logic                               dm_resp_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   arb_outstanding,
  output logic                               arb_err_spurious
);

  arb_id_e grant;
  arb_id_e hold_id;
  arb_id_e head;
  logic    hold_valid;
  logic    hold_live;
  logic    aux_prio;
  logic    gnt_valid;
  logic    full;
  logic    empty;
  logic    accept;
  logic    pop;

`ifdef DMARB_ROUND_ROBIN_EN
  arb_id_e rr_last;

  assign aux_prio = (rr_last == ARB_ID_LSP);

  // Reset value AUX gives p0 the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last <= ARB_ID_AUX;
    end else if (accept) begin
      rr_last <= grant;
    end
  end
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  assign aux_prio = (starve_cnt >= STARVE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!p1_req_valid) begin
      starve_cnt <= '0;
    end else if (accept && (grant == ARB_ID_AUX)) begin
      starve_cnt <= '0;
    end else if (accept && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign hold_live = hold_valid &&
                     ((hold_id == ARB_ID_LSP) ? p0_req_valid : p1_req_valid);

  // A stalled grant sticks only while its owner stays valid; otherwise re-arbitrate now.
  always_comb begin
    grant = ARB_ID_LSP;
    if (hold_live) begin
      grant = hold_id;
    end else if (p1_req_valid && (!p0_req_valid || aux_prio)) begin
      grant = ARB_ID_AUX;
    end
  end

  always_comb begin
    if (grant == ARB_ID_AUX) begin
      gnt_valid    = p1_req_valid;
      dm_req_addr  = p1_req_addr;
      dm_req_wdata = p1_req_wdata;
      dm_req_wmask = p1_req_wmask;
      dm_req_wen   = p1_req_wen;
    end else begin
      gnt_valid    = p0_req_valid;
      dm_req_addr  = p0_req_addr;
      dm_req_wdata = p0_req_wdata;
      dm_req_wmask = p0_req_wmask;
      dm_req_wen   = p0_req_wen;
    end
  end

  assign dm_req_valid = gnt_valid && !full;
  assign accept       = dm_req_valid && dm_req_ready;
  assign p0_req_ready = (grant == ARB_ID_LSP) && dm_req_ready && !full;
  assign p1_req_ready = (grant == ARB_ID_AUX) && dm_req_ready && !full;

  assign pop           = dm_resp_valid && !empty;
  assign p0_resp_valid = pop && (head == ARB_ID_LSP);
  assign p1_resp_valid = pop && (head == ARB_ID_AUX);
  assign p0_resp_rdata = dm_resp_rdata;
  assign p1_resp_rdata = dm_resp_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid       <= 1'b0;
      hold_id          <= ARB_ID_LSP;
      arb_err_spurious <= 1'b0;
    end else begin
      hold_valid <= dm_req_valid && !dm_req_ready;
      hold_id    <= grant;
      if (dm_resp_valid && empty) begin
        arb_err_spurious <= 1'b1;
      end
    end
  end

  dm_arb_route_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (grant),
    .pop     (pop),
    .head    (head),
    .count   (arb_outstanding),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: expected response owners queued at accept, checked at response.
module tb_dm_arbiter;

  localparam int unsigned MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] p0_req_addr, p0_req_wdata, p1_req_addr, p1_req_wdata;
  logic [7:0]  p0_req_wmask, p1_req_wmask;
  logic        p0_req_wen, p0_req_valid, p0_req_ready, p0_resp_valid;
  logic        p1_req_wen, p1_req_valid, p1_req_ready, p1_resp_valid;
  logic [63:0] p0_resp_rdata, p1_resp_rdata;
  logic [63:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_wen, dm_req_valid, dm_req_ready, dm_resp_valid;
  logic [$clog2(MAXO):0] arb_outstanding;
  logic        arb_err_spurious;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        exp_q[$];

  always #5 clk = ~clk;

  dm_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .p0_req_addr      (p0_req_addr),
    .p0_req_wdata     (p0_req_wdata),
    .p0_req_wmask     (p0_req_wmask),
    .p0_req_wen       (p0_req_wen),
    .p0_req_valid     (p0_req_valid),
    .p0_req_ready     (p0_req_ready),
    .p0_resp_valid    (p0_resp_valid),
    .p0_resp_rdata    (p0_resp_rdata),
    .p1_req_addr      (p1_req_addr),
    .p1_req_wdata     (p1_req_wdata),
    .p1_req_wmask     (p1_req_wmask),
    .p1_req_wen       (p1_req_wen),
    .p1_req_valid     (p1_req_valid),
    .p1_req_ready     (p1_req_ready),
    .p1_resp_valid    (p1_resp_valid),
    .p1_resp_rdata    (p1_resp_rdata),
    .dm_req_addr      (dm_req_addr),
    .dm_req_wdata     (dm_req_wdata),
    .dm_req_wmask     (dm_req_wmask),
    .dm_req_wen       (dm_req_wen),
    .dm_req_valid     (dm_req_valid),
    .dm_req_ready     (dm_req_ready),
    .dm_resp_rdata    (dm_resp_rdata),
    .dm_resp_valid    (dm_resp_valid),
    .arb_outstanding  (arb_outstanding),
    .arb_err_spurious (arb_err_spurious)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req_valid  = 1'b0;
    p1_req_valid  = 1'b0;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
  endtask

  // Caller has driven dm_resp_valid/rdata and let combinational outputs settle.
  task automatic check_resp(input logic [63:0] data);
    logic id;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      id = exp_q.pop_front();
      check("resp_p0_valid", p0_resp_valid, !id);
      check("resp_p1_valid", p1_resp_valid, id);
      check("resp_rdata", id ? p1_resp_rdata : p0_resp_rdata, data);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic g;
    logic [3:0] ids;
    rst = 1'b0;
    idle_inputs();
    p0_req_addr = '0; p0_req_wdata = 64'h5555; p0_req_wmask = 8'hFF; p0_req_wen = 1'b0;
    p1_req_addr = '0; p1_req_wdata = 64'hAAAA; p1_req_wmask = 8'h0F; p1_req_wen = 1'b1;
    dm_resp_rdata = '0;
    #1;
    check("rst_count", arb_outstanding, 0);
    check("rst_err", arb_err_spurious, 0);
    check("rst_dm_valid", dm_req_valid, 0);
    check("rst_p0_ready", p0_req_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single p0 load, response two cycles later
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_addr = 64'h1000; dm_req_ready = 1'b1;
    #1;
    check("t1_p0_ready", p0_req_ready, 1);
    check("t1_addr", dm_req_addr, 64'h1000);
    check("t1_wen", dm_req_wen, 0);
    exp_q.push_back(1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t1_count1", arb_outstanding, 1);
    @(negedge clk);
    dm_resp_valid = 1'b1; dm_resp_rdata = 64'hDEADBEEF;
    #1;
    check_resp(64'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t1_count0", arb_outstanding, 0);

    // Both valid continuously: starvation guard or round-robin
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      p0_req_valid = 1'b1; p0_req_addr = 64'h2000 + 64'(k);
      p1_req_valid = 1'b1; p1_req_addr = 64'h3000 + 64'(k);
      dm_req_ready = 1'b1;
      dm_resp_valid = (k > 0); dm_resp_rdata = 64'h100 + 64'(k);
      #1;
`ifdef DMARB_ROUND_ROBIN_EN
      g = k[0];
`else
      g = (k == 8);
`endif
      check("t2_p0_ready", p0_req_ready, !g);
      check("t2_p1_ready", p1_req_ready, g);
      check("t2_addr", dm_req_addr, g ? 64'h3000 + 64'(k) : 64'h2000 + 64'(k));
      if (k > 0) check_resp(64'h100 + 64'(k));
      exp_q.push_back(g);
    end
    @(negedge clk);
    idle_inputs();
    dm_resp_valid = 1'b1; dm_resp_rdata = 64'h1FF;
    #1;
    check_resp(64'h1FF);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t2_count0", arb_outstanding, 0);

    // Grant held on p1 through backpressure while p0 arrives
    @(negedge clk);
    p1_req_valid = 1'b1; p1_req_addr = 64'h4000; dm_req_ready = 1'b0;
    #1;
    check("t3_dm_valid", dm_req_valid, 1);
    check("t3_addr0", dm_req_addr, 64'h4000);
    check("t3_p1_ready0", p1_req_ready, 0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      p0_req_valid = 1'b1; p0_req_addr = 64'h5000;
      #1;
      check("t3_addr_hold", dm_req_addr, 64'h4000);
      check("t3_p0_ready_hold", p0_req_ready, 0);
      check("t3_wen_hold", dm_req_wen, 1);
    end
    @(negedge clk);
    dm_req_ready = 1'b1;
    #1;
    check("t3_p1_accept", p1_req_ready, 1);
    check("t3_p0_wait", p0_req_ready, 0);
    check("t3_addr_acc", dm_req_addr, 64'h4000);
    exp_q.push_back(1'b1);
    @(negedge clk);
    p1_req_valid = 1'b0;
    #1;
    check("t3_p0_accept", p0_req_ready, 1);
    check("t3_p0_addr", dm_req_addr, 64'h5000);
    exp_q.push_back(1'b0);
    @(negedge clk);
    idle_inputs();
    dm_resp_valid = 1'b1; dm_resp_rdata = 64'hA1;
    #1;
    check_resp(64'hA1);
    @(negedge clk);
    dm_resp_rdata = 64'hA2;
    #1;
    check_resp(64'hA2);

    // Fill to MAX_OUTSTANDING; a response does not free a slot in the same cycle
    for (int i = 0; i < int'(MAXO); i++) begin
      @(negedge clk);
      idle_inputs();
      p0_req_valid = 1'b1; p0_req_addr = 64'h6000 + 64'(i); dm_req_ready = 1'b1;
      #1;
      check("t4_fill_ready", p0_req_ready, 1);
      exp_q.push_back(1'b0);
    end
    @(negedge clk);
    p0_req_addr = 64'h6010;
    #1;
    check("t4_count_full", arb_outstanding, MAXO);
    check("t4_p0_ready_full", p0_req_ready, 0);
    check("t4_p1_ready_full", p1_req_ready, 0);
    check("t4_dm_valid_full", dm_req_valid, 0);
    @(negedge clk);
    dm_resp_valid = 1'b1; dm_resp_rdata = 64'hC0;
    #1;
    check("t4_p0_ready_pop", p0_req_ready, 0);
    check_resp(64'hC0);
    @(negedge clk);
    dm_resp_valid = 1'b0;
    #1;
    check("t4_count_after_pop", arb_outstanding, MAXO - 1);
    check("t4_p0_accept", p0_req_ready, 1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(MAXO); i++) begin
      @(negedge clk);
      idle_inputs();
      dm_resp_valid = 1'b1; dm_resp_rdata = 64'hC1 + 64'(i);
      #1;
      check_resp(64'hC1 + 64'(i));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("t4_count0", arb_outstanding, 0);

    // Interleaved owners p0,p1,p1,p0 routed in issue order
    ids = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      dm_req_ready = 1'b1;
      p0_req_valid = !ids[i]; p0_req_addr = 64'h7000 + 64'(i);
      p1_req_valid = ids[i];  p1_req_addr = 64'h7100 + 64'(i);
      #1;
      check("t5_ready", ids[i] ? p1_req_ready : p0_req_ready, 1);
      check("t5_other_ready", ids[i] ? p0_req_ready : p1_req_ready, 0);
      exp_q.push_back(ids[i]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      dm_resp_valid = 1'b1; dm_resp_rdata = 64'hB0 + 64'(i);
      #1;
      check_resp(64'hB0 + 64'(i));
    end

    // Spurious response, then reset mid-burst
    @(negedge clk);
    idle_inputs();
    dm_resp_valid = 1'b1; dm_resp_rdata = 64'hEE;
    #1;
    check("t6_spur_p0", p0_resp_valid, 0);
    check("t6_spur_p1", p1_resp_valid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t6_err_set", arb_err_spurious, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      p0_req_valid = 1'b1; p0_req_addr = 64'h8000 + 64'(i); dm_req_ready = 1'b1;
      #1;
      check("t6_burst_ready", p0_req_ready, 1);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_count", arb_outstanding, 0);
    check("t6_rst_err", arb_err_spurious, 0);
    check("t6_rst_dm_valid", dm_req_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dm_resp_valid = 1'b1; dm_resp_rdata = 64'hF0;
    #1;
    check("t6_stale_p0", p0_resp_valid, 0);
    check("t6_stale_p1", p1_resp_valid, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t6_stale_err", arb_err_spurious, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
